// File: rtl/text_buffer_writer.sv
// Producer side of the VGA text buffer: accepts ASCII bytes, tracks the cursor,
// and performs clear / scroll sweeps over the 256-cell character array.
module text_buffer_writer #(
    parameter int         COLS       = 32,
    parameter int         ROWS       = 8,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [7:0]                wr_char,
    output logic                      wr_ready,
    output logic [7:0]                char_data [0:COLS*ROWS-1],
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      busy
);

    localparam int CELLS  = COLS * ROWS;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int CELL_W = $clog2(CELLS);
    localparam int IDX_W  = CELL_W + 1;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0]  SHIFT_END = IDX_W'(CELLS - COLS);
    localparam logic [CELL_W-1:0] COL_STEP  = CELL_W'(COLS);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SCROLL
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         cells_q [0:CELLS-1];
    logic [7:0]         cells_d [0:CELLS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < CELLS; i++) begin
                cells_q[i] <= BLANK_CHAR;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            cells_q <= cells_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        cells_d = cells_q;

        case (state_q)
            S_IDLE: begin
                if (wr_valid) begin
                    if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
                        cells_d[{row_q, col_q}] = wr_char;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            // Cursor stays on the bottom row; the sweep shifts the text up under it.
                            if (row_q != LAST_ROW) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                state_d = S_SCROLL;
                                idx_d   = '0;
                            end
                        end
                    end else begin
                        case (wr_char)
                            CH_LF: begin
                                col_d = '0;
                                if (row_q != LAST_ROW) begin
                                    row_d = row_q + 1'b1;
                                end else begin
                                    state_d = S_SCROLL;
                                    idx_d   = '0;
                                end
                            end
                            CH_CR: col_d = '0;
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_d = col_q - 1'b1;
                                    cells_d[{row_q, col_q - 1'b1}] = BLANK_CHAR;
                                end else if (row_q != '0) begin
                                    row_d = row_q - 1'b1;
                                    col_d = LAST_COL;
                                    cells_d[{row_q - 1'b1, LAST_COL}] = BLANK_CHAR;
                                end
                            end
                            CH_FF: begin
                                row_d   = '0;
                                col_d   = '0;
                                idx_d   = '0;
                                state_d = S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_CLEAR: begin
                cells_d[idx_q[CELL_W-1:0]] = BLANK_CHAR;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_SCROLL: begin
                // Ascending sweep: the source cell one row below is always still unmodified.
                if (idx_q < SHIFT_END) begin
                    cells_d[idx_q[CELL_W-1:0]] = cells_q[idx_q[CELL_W-1:0] + COL_STEP];
                end else begin
                    cells_d[idx_q[CELL_W-1:0]] = BLANK_CHAR;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign wr_ready   = (state_q == S_IDLE);
    assign busy       = ~wr_ready;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign char_data  = cells_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: a screen-level model checked every
// cycle, plus literal expectations at key points of the scenario.
module tb_text_buffer_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_char = 8'h00;
    logic       wr_ready;
    logic [7:0] char_data [0:255];
    logic [2:0] cursor_row;
    logic [4:0] cursor_col;
    logic       busy;

    int checks = 0;
    int failures = 0;

    text_buffer_writer #(.COLS(32), .ROWS(8), .BLANK_CHAR(8'h20)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_char    (wr_char),
        .wr_ready   (wr_ready),
        .char_data  (char_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Screen model: whole-screen effects are applied at once, then the model
    // simply counts down the 256 busy cycles.
    logic [7:0] m_cells [0:255];
    int m_row = 0;
    int m_col = 0;
    int m_busy = 0;

    task automatic m_scroll();
        for (int i = 0; i < 224; i++) m_cells[i] = m_cells[i + 32];
        for (int i = 224; i < 256; i++) m_cells[i] = 8'h20;
        m_busy = 256;
    endtask

    task automatic m_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_cells[m_row * 32 + m_col] = c;
            if (m_col < 31) m_col++;
            else begin
                m_col = 0;
                if (m_row < 7) m_row++;
                else m_scroll();
            end
        end else if (c == 8'h0A) begin
            m_col = 0;
            if (m_row < 7) m_row++;
            else m_scroll();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_cells[m_row * 32 + m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 31;
                m_cells[m_row * 32 + m_col] = 8'h20;
            end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < 256; i++) m_cells[i] = 8'h20;
            m_row = 0;
            m_col = 0;
            m_busy = 256;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) m_cells[i] = 8'h20;
            m_row = 0;
            m_col = 0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (wr_valid) begin
            m_apply(wr_char);
        end
    end

    always @(negedge clk) begin
        int bad;
        checks++;
        if (wr_ready !== (m_busy == 0) || busy !== (m_busy != 0) ||
            int'(cursor_row) != m_row || int'(cursor_col) != m_col) begin
            failures++;
            $display("FAIL model_ctrl t=%0t got ready=%0b busy=%0b cur=(%0d,%0d) want ready=%0b cur=(%0d,%0d)",
                     $time, wr_ready, busy, cursor_row, cursor_col, (m_busy == 0), m_row, m_col);
        end
        if (m_busy == 0) begin
            checks++;
            bad = -1;
            for (int i = 0; i < 256; i++) begin
                if (char_data[i] !== m_cells[i] && bad < 0) bad = i;
            end
            if (bad >= 0) begin
                failures++;
                $display("FAIL model_cells t=%0t cell=%0d got=%h want=%h",
                         $time, bad, char_data[bad], m_cells[bad]);
            end
        end
    end

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge; holds the byte until accepted, returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        wr_char = b;
        wr_valid = 1'b1;
        while (!wr_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%h got ready=0 want ready=1", b);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        int bad;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", int'(wr_ready), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_cell77", int'(char_data[77]), 8'h20);
        reset = 1'b1;

        send(8'h48);
        send(8'h69);
        check_eq("hi_cell0", int'(char_data[0]), 8'h48);
        check_eq("hi_cell1", int'(char_data[1]), 8'h69);
        check_eq("hi_cell2", int'(char_data[2]), 8'h20);
        check_eq("hi_col", int'(cursor_col), 2);
        check_eq("hi_row", int'(cursor_row), 0);
        check_eq("hi_ready", int'(wr_ready), 1);

        for (int i = 0; i < 29; i++) send(8'(8'h61 + i % 26));
        check_eq("fill_col31", int'(cursor_col), 31);
        send(8'h41);
        check_eq("wrap_cell31", int'(char_data[31]), 8'h41);
        check_eq("wrap_row", int'(cursor_row), 1);
        check_eq("wrap_col", int'(cursor_col), 0);

        send(8'h08);
        check_eq("bs_row", int'(cursor_row), 0);
        check_eq("bs_col", int'(cursor_col), 31);
        check_eq("bs_cell31", int'(char_data[31]), 8'h20);

        send(8'h0D);
        send(8'h08);
        check_eq("bs00_row", int'(cursor_row), 0);
        check_eq("bs00_col", int'(cursor_col), 0);
        check_eq("bs00_cell0", int'(char_data[0]), 8'h48);
        send(8'h01);

        send(8'h0C);
        wait_idle(cnt);
        check_eq("clear1_busy_cycles", cnt, 256);

        for (int i = 0; i < 255; i++) send(8'(8'h21 + i % 94));
        check_eq("full_row", int'(cursor_row), 7);
        check_eq("full_col", int'(cursor_col), 31);
        check_eq("full_cell254", int'(char_data[254]), 8'h63);

        send(8'h0A);
        check_eq("lf_scroll_busy", int'(busy), 1);
        wait_idle(cnt);
        check_eq("scroll_busy_cycles", cnt, 256);
        check_eq("scroll_cell0", int'(char_data[0]), 8'h41);
        check_eq("scroll_cell222", int'(char_data[222]), 8'h63);
        check_eq("scroll_cell223", int'(char_data[223]), 8'h20);
        check_eq("scroll_cell224", int'(char_data[224]), 8'h20);
        check_eq("scroll_cell255", int'(char_data[255]), 8'h20);
        check_eq("scroll_row", int'(cursor_row), 7);
        check_eq("scroll_col", int'(cursor_col), 0);

        for (int k = 0; k < 32; k++) send(8'(8'h30 + k));
        send(8'h51);
        check_eq("pscroll_cell192", int'(char_data[192]), 8'h30);
        check_eq("pscroll_cell223", int'(char_data[223]), 8'h4F);
        check_eq("pscroll_cell224", int'(char_data[224]), 8'h51);
        check_eq("pscroll_col", int'(cursor_col), 1);

        send(8'h0C);
        repeat (99) @(negedge clk);
        check_eq("midclr_busy", int'(busy), 1);
        check_eq("midclr_cell200", int'(char_data[200]), 8'h38);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_ready", int'(wr_ready), 1);
        check_eq("async_rst_busy", int'(busy), 0);
        check_eq("async_rst_row", int'(cursor_row), 0);
        check_eq("async_rst_col", int'(cursor_col), 0);
        check_eq("async_rst_cell200", int'(char_data[200]), 8'h20);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", int'(wr_ready), 1);

        send(8'h48);
        send(8'h69);
        send(8'h0C);
        wait_idle(cnt);
        check_eq("clear2_busy_cycles", cnt, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (char_data[i] !== 8'h20) bad++;
        check_eq("clear2_nonblank_cells", bad, 0);
        check_eq("clear2_row", int'(cursor_row), 0);
        check_eq("clear2_col", int'(cursor_col), 0);
        check_eq("clear2_ready", int'(wr_ready), 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
Producer side of the 256-cell character buffer that the VGA text renderer scans through char_data.
- Accepts ASCII bytes from the CPU over a valid/ready handshake.
- Maintains a cursor and writes printable characters into the buffer.
- Handles newline, backspace and clear.
- Scrolls the screen up one row when the cursor runs off the bottom.
- Drives the char_data array consumed by the VGA block.

Parameters:
- COLS, 32, characters per row; power of two; COLS*ROWS must equal 256.
- ROWS, 8, rows on screen.
- BLANK_CHAR, 8'h20, fill value for cleared/scrolled cells.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  CPU presents a byte on wr_char.
- wr_char  input  8  ASCII byte or control code.
- wr_ready  output  1  writer can accept a byte this cycle.
- char_data  output  8 x 256  buffer contents, cell index = row*COLS + col.
- cursor_row  output  log2(ROWS)  current cursor row.
- cursor_col  output  log2(COLS)  current cursor column.
- busy  output  1  high while in CLEAR or SCROLL.

Behaviour:
- Reset (reset low, asynchronous):
  - all 256 cells = BLANK_CHAR; cursor_row = 0; cursor_col = 0.
  - state = IDLE; wr_ready = 1; busy = 0.
- Handshake:
  - A byte is accepted on a rising edge with wr_valid=1 and wr_ready=1.
  - wr_ready = (state==IDLE); busy = !wr_ready.
  - wr_char is ignored when wr_ready=0; the CPU must hold it until accepted.
- States: IDLE, CLEAR, SCROLL. A 9-bit-safe cell counter idx (0..255) is used in CLEAR and SCROLL.
- IDLE, accepted byte, by class:
  - Printable 0x20..0x7E:
    - cell[row*COLS+col] <= byte; visible on char_data the edge after acceptance (latency 1).
    - If col < COLS-1: col+1.
    - Else col <= 0; if row < ROWS-1, row+1; else row stays ROWS-1 and go to SCROLL.
  - 0x0A newline:
    - col <= 0.
    - If row < ROWS-1, row+1; else go to SCROLL (row stays ROWS-1).
  - 0x0D carriage return: col <= 0.
  - 0x08 backspace:
    - If col > 0: col-1 and that cell <= BLANK_CHAR.
    - Else if row > 0: row-1, col <= COLS-1, that cell <= BLANK_CHAR.
    - At (0,0): no effect.
  - 0x0C form feed: cursor <= (0,0), idx <= 0, go to CLEAR.
  - Any other code: accepted, no effect.
- CLEAR:
  - Each cycle cell[idx] <= BLANK_CHAR, idx+1.
  - After idx=255 is written, return to IDLE; takes 256 cycles total.
- SCROLL:
  - Each cycle, for idx < 256-COLS: cell[idx] <= cell[idx+COLS]; otherwise cell[idx] <= BLANK_CHAR; then idx+1.
  - After idx=255, return to IDLE (256 cycles); the cursor is (ROWS-1, 0) throughout.
  - The printable byte that triggered the scroll was already written to the last cell before the scroll started, so it ends up at cell 256-COLS-1 (last column of row ROWS-2).
- While in CLEAR or SCROLL, char_data changes progressively; partial frames on the display are acceptable.
- idx wraps only through the explicit return to IDLE; no cell outside 0..255 is ever addressed.
- reset asserted mid-CLEAR or mid-SCROLL: immediate full reset state; the operation is not resumed.
- wr_valid held high continuously: one byte is accepted per IDLE cycle; none are accepted during CLEAR or SCROLL.

Test Plan:
- Reset release, then send 'H'(0x48), 'i'(0x69) → cell0=0x48, cell1=0x69, cursor (0,2), all other cells 0x20, wr_ready stays 1.
- From (0,31), send 'A' → cell31=0x41, cursor (1,0).
- From (1,0), send 0x08 → cursor (0,31), cell31=0x20.
- At (0,0), send 0x08 → no change.
- Fill rows 0..7 with distinct bytes, then send 0x0A at row 7:
  - busy=1, wr_ready=0 for exactly 256 cycles.
  - Afterwards cells 0..223 hold the former cells 32..255 and cells 224..255 = 0x20.
  - cursor (7,0).
- Send 0x0C, and separately pulse reset low at cycle 100 of a CLEAR:
  - After a completed CLEAR, all cells are 0x20, cursor (0,0), wr_ready returns exactly 256 cycles after acceptance.
  - On the mid-CLEAR reset pulse, the immediate reset state appears asynchronously, with wr_ready=1 on the next cycle.
